// File: rtl/cpu_pkg.sv
// Shared types and constants for the 64-bit pipeline.
// Branch kinds, ARM-style condition codes and the NZCV flag layout.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  // Packed MSB-first as {n,z,c,v}, matching the flags_nzcv output.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: tests a condition code against NZCV.
// C=1 after a subtract means "no borrow", so HS/LO/HI/LS are unsigned compares.
module cond_eval
  import cpu_pkg::*;
(
  input  flags_t flags,
  input  cond_t  cond,
  output logic   taken
);

  // Decode the condition code into a taken decision.
  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_HS: taken = flags.c;
      COND_LO: taken = !flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = !flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = !flags.v;
      COND_HI: taken = flags.c && !flags.z;
      COND_LS: taken = !flags.c || flags.z;
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = !flags.z && (flags.n == flags.v);
      COND_LE: taken = flags.z || (flags.n != flags.v);
      default: taken = 1'b1;  // AL and NV are both always taken
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with the architectural NZCV flags and
// conditional-branch resolution. All outputs come straight from flops.
//
// Pipeline handshake: ex_valid marks a real instruction in EX; it moves into
// MEM on a rising edge when neither stall nor flush is high. stall freezes
// every register (and wins over flush); otherwise a non-captured cycle
// inserts a bubble (mem_valid=0, all side-effect controls cleared).
module ex_mem_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry,
  input  logic              ex_set_flags,
  input  logic [1:0]        ex_br_type,
  input  logic [3:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_branch_taken,
  output logic [3:0]        flags_nzcv
);

  logic [1:0]        rst_sync_q;
  logic              rst_n_int;
  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] store_q;
  logic [REG_W-1:0]  rd_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              br_taken_q;
  flags_t            flags_q;
  flags_t            flags_d;
  logic              cap;
  logic              cond_taken;
  logic              br_taken_d;

  // Reset asserts immediately but releases two clock edges later, in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // B.cond reads the committed flag register, never the ALU flags in EX.
  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (cond_t'(ex_cond)),
    .taken (cond_taken)
  );

  // Capture decision, branch resolution and next flag value.
  always_comb begin
    cap        = !stall && !flush && ex_valid;
    br_taken_d = 1'b0;
    case (br_type_t'(ex_br_type))
      BR_COND: br_taken_d = cond_taken;
      BR_CBZ:  br_taken_d = ex_zero;
      BR_CBNZ: br_taken_d = !ex_zero;
      default: br_taken_d = 1'b0;
    endcase
    flags_d = flags_q;
    if (cap && ex_set_flags) begin
      flags_d = '{n: ex_negative, z: ex_zero, c: ex_carry, v: ex_overflow};
    end
  end

  // Pipeline register: load on capture, bubble on drop, hold on stall.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      br_taken_q  <= 1'b0;
      flags_q     <= '0;
    end else if (!stall) begin
      flags_q <= flags_d;
      if (cap) begin
        valid_q     <= 1'b1;
        result_q    <= ex_result;
        store_q     <= ex_store_data;
        rd_q        <= ex_rd;
        reg_write_q <= ex_reg_write;
        mem_read_q  <= ex_mem_read;
        mem_write_q <= ex_mem_write;
        br_taken_q  <= br_taken_d;
      end else begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        br_taken_q  <= 1'b0;
      end
    end
  end

  assign mem_valid        = valid_q;
  assign mem_result       = result_q;
  assign mem_store_data   = store_q;
  assign mem_rd           = rd_q;
  assign mem_reg_write    = reg_write_q;
  assign mem_mem_read     = mem_read_q;
  assign mem_mem_write    = mem_write_q;
  assign mem_branch_taken = br_taken_q;
  assign flags_nzcv       = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus random traffic
// checked against a cycle-level reference model of the stage.
module tb_ex_mem_stage;

  localparam int EXP_W = 142;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, flush, ex_valid;
  logic [63:0] ex_result, ex_store_data;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry, ex_set_flags;
  logic [1:0]  ex_br_type;
  logic [3:0]  ex_cond;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken;
  logic [3:0]  flags_nzcv;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic        m_valid, m_rw, m_mr, m_mw, m_bt;
  logic [3:0]  m_nzcv;
  logic [4:0]  m_rd;
  logic [63:0] m_res, m_st;

  logic [EXP_W-1:0] exp_q[$];

  ex_mem_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_result(ex_result), .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry(ex_carry), .ex_set_flags(ex_set_flags),
    .ex_br_type(ex_br_type), .ex_cond(ex_cond), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_branch_taken(mem_branch_taken), .flags_nzcv(flags_nzcv)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural branch rule: condition pairs share a base test, odd codes
  // invert it, except 1111 which is always taken like 1110.
  function automatic logic ref_taken(input logic [1:0] bt, input logic [3:0] cc,
                                     input logic [3:0] f, input logic zero);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (bt)
      2'd0: return 1'b0;
      2'd2: return zero;
      2'd3: return !zero;
      default: begin
        case (cc[3:1])
          3'd0: base = z;
          3'd1: base = c;
          3'd2: base = n;
          3'd3: base = v;
          3'd4: base = c && !z;
          3'd5: base = (n == v);
          3'd6: base = !z && (n == v);
          default: base = 1'b1;
        endcase
        if (cc[0] && cc != 4'hF) base = !base;
        return base;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_bt = 0;
    m_nzcv = 0; m_rd = 0; m_res = 0; m_st = 0;
    exp_q.delete();
  endtask

  // driver tasks
  task automatic set_idle();
    stall = 0; flush = 0; ex_valid = 0; ex_result = 0; ex_store_data = 0;
    ex_negative = 0; ex_zero = 0; ex_overflow = 0; ex_carry = 0; ex_set_flags = 0;
    ex_br_type = 0; ex_cond = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0;
  endtask

  task automatic set_insn(input logic [63:0] res, input logic [3:0] nzcv, input logic sf,
                          input logic [1:0] bt, input logic [3:0] cc, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
    ex_valid = 1; ex_result = res; ex_store_data = ~res;
    {ex_negative, ex_zero, ex_carry, ex_overflow} = nzcv;
    ex_set_flags = sf; ex_br_type = bt; ex_cond = cc; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
  endtask

  task automatic drive_random();
    stall         = ($urandom_range(0, 9) < 2);
    flush         = ($urandom_range(0, 9) < 1);
    ex_valid      = ($urandom_range(0, 9) < 8);
    ex_result     = {$urandom, $urandom};
    ex_store_data = {$urandom, $urandom};
    {ex_negative, ex_zero, ex_carry, ex_overflow} = 4'($urandom_range(0, 15));
    ex_set_flags  = 1'($urandom_range(0, 1));
    ex_br_type    = 2'($urandom_range(0, 3));
    ex_cond       = 4'($urandom_range(0, 15));
    ex_rd         = 5'($urandom_range(0, 31));
    ex_reg_write  = 1'($urandom_range(0, 1));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_mem_write  = 1'($urandom_range(0, 1));
  endtask

  // One clock: advance the model, then check the DUT just after the edge.
  task automatic tick();
    logic [EXP_W-1:0] e;
    logic cap;
    cap = !stall && !flush && ex_valid;
    if (!stall) begin
      if (cap) begin
        m_bt = ref_taken(ex_br_type, ex_cond, m_nzcv, ex_zero);
        m_valid = 1; m_res = ex_result; m_st = ex_store_data; m_rd = ex_rd;
        m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
        if (ex_set_flags) m_nzcv = {ex_negative, ex_zero, ex_carry, ex_overflow};
      end else begin
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_bt = 0;
      end
    end
    exp_q.push_back({m_valid, m_rw, m_mr, m_mw, m_bt, m_nzcv, m_rd, m_res, m_st});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("valid", 64'(mem_valid), 64'(e[141]));
    check("reg_write", 64'(mem_reg_write), 64'(e[140]));
    check("mem_read", 64'(mem_mem_read), 64'(e[139]));
    check("mem_write", 64'(mem_mem_write), 64'(e[138]));
    check("br_taken", 64'(mem_branch_taken), 64'(e[137]));
    check("flags", 64'(flags_nzcv), 64'(e[136:133]));
    if (e[141]) begin
      check("rd", 64'(mem_rd), 64'(e[132:128]));
      check("result", mem_result, e[127:64]);
      check("store", mem_store_data, e[63:0]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"}, {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
                          mem_branch_taken, flags_nzcv, mem_rd}, 64'd0);
    check({tag, "_res"}, mem_result, 64'd0);
    check({tag, "_st"}, mem_store_data, 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    set_idle();
    repeat (3) tick();
  endtask

  initial begin
    set_idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1;
    repeat (3) tick();

    // SUBS (N=1, V=0) then B.GE -> flags 1000, not taken
    set_insn(64'hFFFF_FFFF_FFFF_FFFB, 4'b1000, 1, 2'd0, 4'h0, 5'd3, 1, 0, 0);
    tick();
    check("subs_flags", 64'(flags_nzcv), 64'b1000);
    set_insn(64'h40, 4'b0000, 0, 2'd1, 4'hA, 5'd0, 0, 0, 0);
    tick();
    check("bge_nt", 64'(mem_branch_taken), 64'd0);

    // SUBS with V=1 then B.GE -> taken
    set_insn(64'hFFFF_FFFF_FFFF_FFFB, 4'b1001, 1, 2'd0, 4'h0, 5'd3, 1, 0, 0);
    tick();
    check("subs_v_flags", 64'(flags_nzcv), 64'b1001);
    set_insn(64'h40, 4'b0000, 0, 2'd1, 4'hA, 5'd0, 0, 0, 0);
    tick();
    check("bge_t", 64'(mem_branch_taken), 64'd1);

    // CBZ / CBNZ with zero=1; flags stay 1001
    set_insn(64'h0, 4'b0100, 0, 2'd2, 4'h0, 5'd0, 0, 0, 0);
    tick();
    check("cbz", 64'(mem_branch_taken), 64'd1);
    set_insn(64'h0, 4'b0100, 0, 2'd3, 4'h0, 5'd0, 0, 0, 0);
    tick();
    check("cbnz", 64'(mem_branch_taken), 64'd0);
    check("cb_flags", 64'(flags_nzcv), 64'b1001);

    // stall 3 cycles with ADDS rd=7 in EX
    set_insn(64'h1234, 4'b0110, 1, 2'd0, 4'h0, 5'd7, 1, 0, 0);
    stall = 1;
    repeat (3) tick();
    check("stall_rd", 64'(mem_rd), 64'd0);
    check("stall_flags", 64'(flags_nzcv), 64'b1001);
    flush = 1;
    repeat (2) tick();
    check("stall_flush_valid", 64'(mem_valid), 64'd1);

    // flush an STUR
    stall = 0;
    set_insn(64'h8000, 4'b1111, 1, 2'd0, 4'h0, 5'd0, 0, 0, 1);
    flush = 1;
    tick();
    check("flush_valid", 64'(mem_valid), 64'd0);
    check("flush_mw", 64'(mem_mem_write), 64'd0);
    check("flush_flags", 64'(flags_nzcv), 64'b1001);

    // ADD, no flag set, ALU Z=1
    flush = 0;
    set_insn(64'hDEAD_BEEF_0000_0001, 4'b0100, 0, 2'd0, 4'h0, 5'd9, 1, 0, 0);
    tick();
    check("add_flags", 64'(flags_nzcv), 64'b1001);
    check("add_result", mem_result, 64'hDEAD_BEEF_0000_0001);

    // asynchronous reset mid-stream
    set_insn(64'hFFFF_0000_FFFF_0000, 4'b1111, 1, 2'd2, 4'h0, 5'd31, 1, 1, 1);
    tick();
    reset_n = 0;
    #1;
    check_all_zero("async_reset");
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
